// File: rtl/aes_block_dma.sv
// Block mover: reads 16-byte blocks from memory, passes them through an external AES core
// (optionally CBC-chained) and writes the results back. Configured over a 32-bit CSR slave.
module aes_block_dma #(
    parameter int unsigned MASTER_DW = 8,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // CSR slave
    input  logic [3:0]           slave_address,
    input  logic                 slave_read,
    input  logic                 slave_write,
    input  logic [31:0]          slave_writedata,
    output logic [31:0]          slave_readdata,
    output logic                 slave_waitrequest,
    // source read master
    output logic [ADDR_W-1:0]    master_address,
    output logic                 master_read,
    input  logic                 master_waitrequest,
    input  logic                 master_readdatavalid,
    input  logic [MASTER_DW-1:0] master_readdata,
    // destination write master
    output logic [ADDR_W-1:0]    master2_address,
    output logic                 master2_write,
    output logic [MASTER_DW-1:0] master2_writedata,
    input  logic                 master2_waitrequest,
    // AES core
    output logic                 core_in_valid,
    input  logic                 core_in_ready,
    output logic [127:0]         core_in_data,
    output logic                 core_dir,
    input  logic                 core_out_valid,
    output logic                 core_out_ready,
    input  logic [127:0]         core_out_data,
    output logic                 done
);

    localparam int unsigned       BPB        = MASTER_DW / 8;
    localparam int unsigned       BEATS      = 16 / BPB;
    localparam logic [3:0]        LAST_BEAT  = 4'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BPB);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BPB - 1);

    typedef enum logic [2:0] {StIdle, StRead, StFeed, StWait, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [31:0]         len_q, len_d;
    logic [127:0]        iv_q, iv_d;
    logic                cbc_q, cbc_d, dir_q, dir_d;
    logic                done_sticky_q, done_sticky_d, error_q, error_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [31:0]         remain_q, remain_d;
    logic [3:0]          beat_q, beat_d;
    logic                rd_pend_q, rd_pend_d;
    logic [127:0]        blk_q, blk_d, res_q, res_d, chain_q, chain_d;

    logic busy, ctrl_wr, start, bad_cfg;

    // Status and strobe decode shared by the next-state and output logic
    always_comb begin
        busy    = (state_q == StRead) || (state_q == StFeed) ||
                  (state_q == StWait) || (state_q == StWrite);
        ctrl_wr = slave_write && (slave_address == 4'd0);
        start   = ctrl_wr && slave_writedata[0] && !busy;
        bad_cfg = (len_q == 32'd0) || (len_q[3:0] != 4'd0) ||
                  ((src_q & ALIGN_MASK) != '0) || ((dst_q & ALIGN_MASK) != '0);
    end

    // Next-state: CSR updates and the block-moving FSM
    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        dst_d         = dst_q;
        len_d         = len_q;
        iv_d          = iv_q;
        cbc_d         = cbc_q;
        dir_d         = dir_q;
        done_sticky_d = done_sticky_q;
        error_d       = error_q;
        rd_addr_d     = rd_addr_q;
        wr_addr_d     = wr_addr_q;
        remain_d      = remain_q;
        beat_d        = beat_q;
        rd_pend_d     = rd_pend_q;
        blk_d         = blk_q;
        res_d         = res_q;
        chain_d       = chain_q;

        // Mode bits only change between jobs so a running job keeps a consistent datapath
        if (slave_write && !busy) begin
            case (slave_address)
                4'd0: begin
                    cbc_d = slave_writedata[1];
                    dir_d = slave_writedata[2];
                end
                4'd1: src_d = ADDR_W'(slave_writedata);
                4'd2: dst_d = ADDR_W'(slave_writedata);
                4'd3: len_d = slave_writedata;
                4'd4: iv_d[127:96] = slave_writedata;
                4'd5: iv_d[95:64]  = slave_writedata;
                4'd6: iv_d[63:32]  = slave_writedata;
                4'd7: iv_d[31:0]   = slave_writedata;
                default: ;
            endcase
        end
        if (ctrl_wr) begin
            done_sticky_d = 1'b0;
            error_d       = 1'b0;
        end

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    if (bad_cfg) begin
                        error_d       = 1'b1;
                        done_sticky_d = 1'b1;
                        state_d       = StDone;
                    end else begin
                        rd_addr_d = src_q;
                        wr_addr_d = dst_q;
                        remain_d  = len_q;
                        chain_d   = iv_q;
                        beat_d    = 4'd0;
                        rd_pend_d = 1'b0;
                        state_d   = StRead;
                    end
                end
            end
            StRead: begin
                if (!rd_pend_q) begin
                    if (!master_waitrequest) rd_pend_d = 1'b1;
                end else if (master_readdatavalid) begin
                    // earlier beats shift toward the MSBs so the lowest address lands at [127:120]
                    blk_d     = {blk_q[127-MASTER_DW:0], master_readdata};
                    rd_pend_d = 1'b0;
                    rd_addr_d = rd_addr_q + ADDR_STEP;
                    beat_d    = beat_q + 4'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 4'd0;
                        state_d = StFeed;
                    end
                end
            end
            StFeed: begin
                if (core_in_ready) state_d = StWait;
            end
            StWait: begin
                if (core_out_valid) begin
                    res_d = (cbc_q && dir_q) ? (core_out_data ^ chain_q) : core_out_data;
                    if (cbc_q) chain_d = dir_q ? blk_q : core_out_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (!master2_waitrequest) begin
                    res_d     = res_q << MASTER_DW;
                    wr_addr_d = wr_addr_q + ADDR_STEP;
                    beat_d    = beat_q + 4'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d   = 4'd0;
                        remain_d = remain_q - 32'd16;
                        if (remain_q == 32'd16) begin
                            state_d       = StDone;
                            done_sticky_d = 1'b1;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: bus/core strobes decoded from state, CSR read mux
    always_comb begin
        slave_waitrequest = 1'b0;
        master_address    = rd_addr_q;
        master_read       = (state_q == StRead) && !rd_pend_q;
        master2_address   = wr_addr_q;
        master2_write     = (state_q == StWrite);
        master2_writedata = master2_write ? res_q[127 -: MASTER_DW] : '0;
        core_in_valid     = (state_q == StFeed);
        core_in_data      = '0;
        if (core_in_valid) core_in_data = (cbc_q && !dir_q) ? (blk_q ^ chain_q) : blk_q;
        core_dir          = dir_q;
        core_out_ready    = (state_q == StWait);
        done              = (state_q == StDone);

        slave_readdata = 32'd0;
        if (slave_read) begin
            case (slave_address)
                4'd0: slave_readdata = {29'd0, error_q, done_sticky_q, busy};
                4'd1: slave_readdata = 32'(src_q);
                4'd2: slave_readdata = 32'(dst_q);
                4'd3: slave_readdata = len_q;
                4'd4: slave_readdata = iv_q[127:96];
                4'd5: slave_readdata = iv_q[95:64];
                4'd6: slave_readdata = iv_q[63:32];
                4'd7: slave_readdata = iv_q[31:0];
                default: slave_readdata = 32'd0;
            endcase
        end
    end

    // State and CSR registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            iv_q          <= '0;
            cbc_q         <= 1'b0;
            dir_q         <= 1'b0;
            done_sticky_q <= 1'b0;
            error_q       <= 1'b0;
            rd_addr_q     <= '0;
            wr_addr_q     <= '0;
            remain_q      <= '0;
            beat_q        <= '0;
            rd_pend_q     <= 1'b0;
            blk_q         <= '0;
            res_q         <= '0;
            chain_q       <= '0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            iv_q          <= iv_d;
            cbc_q         <= cbc_d;
            dir_q         <= dir_d;
            done_sticky_q <= done_sticky_d;
            error_q       <= error_d;
            rd_addr_q     <= rd_addr_d;
            wr_addr_q     <= wr_addr_d;
            remain_q      <= remain_d;
            beat_q        <= beat_d;
            rd_pend_q     <= rd_pend_d;
            blk_q         <= blk_d;
            res_q         <= res_d;
            chain_q       <= chain_d;
        end
    end

endmodule

// File: tb/tb_aes_block_dma.sv
// Testbench for aes_block_dma (32-bit master build): memory, bus and AES-core stub responders,
// a block-level reference model, and directed plus randomized jobs.
module tb_aes_block_dma;

    localparam int unsigned DW     = 32;
    localparam int unsigned BPB    = DW / 8;
    localparam int unsigned MEM_SZ = 4096;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     slave_address = '0;
    logic           slave_read = 1'b0;
    logic           slave_write = 1'b0;
    logic [31:0]    slave_writedata = '0;
    logic [31:0]    slave_readdata;
    logic           slave_waitrequest;
    logic [31:0]    master_address;
    logic           master_read;
    logic           master_waitrequest = 1'b0;
    logic           master_readdatavalid = 1'b0;
    logic [DW-1:0]  master_readdata = '0;
    logic [31:0]    master2_address;
    logic           master2_write;
    logic [DW-1:0]  master2_writedata;
    logic           master2_waitrequest = 1'b0;
    logic           core_in_valid;
    logic           core_in_ready = 1'b0;
    logic [127:0]   core_in_data;
    logic           core_dir;
    logic           core_out_valid = 1'b0;
    logic           core_out_ready;
    logic [127:0]   core_out_data = '0;
    logic           done;

    always #5 clk = ~clk;

    aes_block_dma #(.MASTER_DW(DW), .ADDR_W(32)) u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .slave_readdata       (slave_readdata),
        .slave_waitrequest    (slave_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_waitrequest   (master_waitrequest),
        .master_readdatavalid (master_readdatavalid),
        .master_readdata      (master_readdata),
        .master2_address      (master2_address),
        .master2_write        (master2_write),
        .master2_writedata    (master2_writedata),
        .master2_waitrequest  (master2_waitrequest),
        .core_in_valid        (core_in_valid),
        .core_in_ready        (core_in_ready),
        .core_in_data         (core_in_data),
        .core_dir             (core_dir),
        .core_out_valid       (core_out_valid),
        .core_out_ready       (core_out_ready),
        .core_out_data        (core_out_data),
        .done                 (done)
    );

    logic [7:0]   mem [0:MEM_SZ-1];
    logic [7:0]   exp_q [$];
    int           checks = 0;
    int           errors = 0;

    // responder configuration (written by the stimulus only)
    bit           rand_bus = 1'b0;
    logic [127:0] core_mask = '0;
    int           core_lat = 0;

    // responder bookkeeping (written by the responder only, cumulative)
    int           n_reads = 0, n_writes = 0, n_done = 0, n_req = 0, viol = 0;
    logic         sv_read = 1'b0, sv_wr = 1'b0, sv_cin = 1'b0, sv_cout_rdy = 1'b0;
    logic [31:0]  sv_raddr = '0, sv_waddr = '0;
    logic [DW-1:0] sv_wdata = '0;
    logic [127:0] sv_cin_data = '0, core_hold = '0;
    logic         rd_pend = 1'b0, core_busy = 1'b0;
    int           rd_addr = 0, rd_dly = 0, core_cnt = 0;

    // Bus memory and AES-core stub. Runs on the falling edge: first settles the handshakes of
    // the rising edge just past (using values latched last falling edge), then drives new inputs.
    always @(negedge clk) begin
        if (!rst_n) begin
            master_waitrequest = 1'b0; master_readdatavalid = 1'b0; master_readdata = '0;
            master2_waitrequest = 1'b0; core_in_ready = 1'b0; core_out_valid = 1'b0;
            core_out_data = '0;
            sv_read = 1'b0; sv_wr = 1'b0; sv_cin = 1'b0; sv_cout_rdy = 1'b0;
            rd_pend = 1'b0; core_busy = 1'b0;
        end else begin
            // source port
            master_readdatavalid = 1'b0;
            if (sv_read && !master_waitrequest) begin
                if (rd_pend) viol++;
                rd_pend = 1'b1; rd_addr = int'(sv_raddr); n_reads++;
                rd_dly = rand_bus ? int'($urandom_range(0, 2)) : 0;
            end
            if (sv_read && master_waitrequest && (!master_read || master_address != sv_raddr))
                viol++;
            if (rd_pend) begin
                if (rd_dly == 0) begin
                    master_readdatavalid = 1'b1;
                    for (int b = 0; b < BPB; b++)
                        master_readdata[DW-1-8*b -: 8] = mem[(rd_addr + b) % MEM_SZ];
                    rd_pend = 1'b0;
                end else begin
                    rd_dly--;
                end
            end
            if (master_read && (rd_pend || master_readdatavalid)) viol++;
            sv_read  = master_read;
            sv_raddr = master_address;
            master_waitrequest = rand_bus ? ($urandom_range(0, 2) == 0) : 1'b0;

            // destination port
            if (sv_wr && !master2_waitrequest) begin
                for (int b = 0; b < BPB; b++)
                    mem[(int'(sv_waddr) + b) % MEM_SZ] = sv_wdata[DW-1-8*b -: 8];
                n_writes++;
            end
            if (sv_wr && master2_waitrequest && (!master2_write || master2_address != sv_waddr ||
                                                 master2_writedata != sv_wdata))
                viol++;
            sv_wr    = master2_write;
            sv_waddr = master2_address;
            sv_wdata = master2_writedata;
            master2_waitrequest = rand_bus ? ($urandom_range(0, 2) == 0) : 1'b0;

            // core stub: out = in ^ core_mask after core_lat cycles
            if (sv_cout_rdy && core_out_valid) begin
                core_out_valid = 1'b0; core_busy = 1'b0;
            end
            if (sv_cin && core_in_ready) begin
                core_busy = 1'b1; core_hold = sv_cin_data ^ core_mask; core_cnt = core_lat;
            end
            if (sv_cin && !core_in_ready && (!core_in_valid || core_in_data != sv_cin_data))
                viol++;
            if (core_busy && !core_out_valid) begin
                if (core_cnt == 0) begin
                    core_out_valid = 1'b1; core_out_data = core_hold;
                end else begin
                    core_cnt--;
                end
            end
            sv_cin      = core_in_valid;
            sv_cin_data = core_in_data;
            sv_cout_rdy = core_out_ready;
            core_in_ready = !core_busy && (!rand_bus || $urandom_range(0, 1) == 1);

            if (done) n_done++;
            if (master_read || master2_write || core_in_valid) n_req++;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    // combinational read, no clock edge consumed
    task automatic csr_peek(input logic [3:0] a, output logic [31:0] d);
        slave_address = a; slave_read = 1'b1;
        #1 d = slave_readdata;
        slave_read = 1'b0;
    endtask

    // Reference model: whole blocks with the core modelled as x ^ core_mask
    task automatic build_expect(input int src, input int len, input bit cbc, input bit dir,
                                input logic [127:0] iv);
        logic [127:0] chain, blk, o;
        exp_q.delete();
        chain = iv;
        for (int k = 0; k < len / 16; k++) begin
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = mem[src + 16*k + i];
            if (!cbc) begin
                o = blk ^ core_mask;
            end else if (!dir) begin
                o = (blk ^ chain) ^ core_mask;
                chain = o;
            end else begin
                o = (blk ^ core_mask) ^ chain;
                chain = blk;
            end
            for (int i = 0; i < 16; i++) exp_q.push_back(o[127-8*i -: 8]);
        end
    endtask

    task automatic program_job(input int src, input int dst, input int len,
                               input logic [127:0] iv);
        csr_write(4'd1, 32'(src));
        csr_write(4'd2, 32'(dst));
        csr_write(4'd3, 32'(len));
        for (int k = 0; k < 4; k++) csr_write(4'(4 + k), iv[127-32*k -: 32]);
    endtask

    task automatic run_job(input string tag, input int src, input int dst, input int len,
                           input bit cbc, input bit dir, input logic [127:0] iv, input bit poke);
        int r0, w0, d0, v0, cyc, nbad;
        logic [31:0] st;
        for (int i = 0; i < len + 4; i++) mem[dst + i] = 8'hA5;
        build_expect(src, len, cbc, dir, iv);
        program_job(src, dst, len, iv);
        r0 = n_reads; w0 = n_writes; d0 = n_done; v0 = viol;
        csr_write(4'd0, {29'd0, dir, cbc, 1'b1});
        chk({tag, "_read_at_t1"}, 128'(master_read), 128'd1);
        csr_peek(4'd0, st);
        chk({tag, "_busy_at_t1"}, 128'(st), 128'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 6) begin
                csr_write(4'd0, {29'd0, !dir, !cbc, 1'b1});
                csr_write(4'd1, 32'(src + 'h40));
            end
        end
        chk({tag, "_done_seen"}, 128'(done), 128'd1);
        csr_peek(4'd0, st);
        chk({tag, "_status_at_done"}, 128'(st), 128'd2);
        repeat (3) @(negedge clk);
        chk({tag, "_done_pulses"}, 128'(n_done - d0), 128'd1);
        chk({tag, "_reads"}, 128'(n_reads - r0), 128'(len / BPB));
        chk({tag, "_writes"}, 128'(n_writes - w0), 128'(len / BPB));
        chk({tag, "_protocol"}, 128'(viol - v0), 128'd0);
        nbad = 0;
        for (int i = 0; i < len; i++) if (mem[dst + i] !== exp_q[i]) nbad++;
        for (int i = len; i < len + 4; i++) if (mem[dst + i] !== 8'hA5) nbad++;
        chk({tag, "_data_bad_bytes"}, 128'(nbad), 128'd0);
        if (poke) begin
            csr_peek(4'd1, st);
            chk({tag, "_src_readback"}, 128'(st), 128'(src));
        end
    endtask

    task automatic run_bad(input string tag, input int src, input int dst, input int len);
        int d0, q0;
        logic [31:0] st;
        program_job(src, dst, len, 128'd0);
        d0 = n_done; q0 = n_req;
        csr_write(4'd0, 32'h1);
        chk({tag, "_done_at_t1"}, 128'(done), 128'd1);
        csr_peek(4'd0, st);
        chk({tag, "_status"}, 128'(st), 128'd6);
        repeat (8) @(negedge clk);
        chk({tag, "_done_pulses"}, 128'(n_done - d0), 128'd1);
        chk({tag, "_no_bus"}, 128'(n_req - q0), 128'd0);
        csr_peek(4'd0, st);
        chk({tag, "_status_hold"}, 128'(st), 128'd6);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_strobes"}, 128'({master_read, master2_write, core_in_valid, core_out_ready,
                                     done, core_dir}), 128'd0);
        chk({tag, "_addrs"}, 128'({master_address, master2_address}), 128'd0);
        chk({tag, "_wdata"}, 128'(master2_writedata), 128'd0);
        chk({tag, "_core_in_data"}, core_in_data, 128'd0);
    endtask

    initial begin
        logic [31:0]  st;
        logic [127:0] iv;
        int           cyc, w0, len, src, dst;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);

        // reset
        repeat (3) @(negedge clk);
        chk_outputs_zero("rst_held");
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_outputs_zero("rst_released");
        chk("rst_waitrequest", 128'(slave_waitrequest), 128'd0);
        csr_peek(4'd0, st); chk("rst_status", 128'(st), 128'd0);
        csr_peek(4'd1, st); chk("rst_src", 128'(st), 128'd0);
        csr_peek(4'd3, st); chk("rst_len", 128'(st), 128'd0);
        csr_peek(4'd4, st); chk("rst_iv0", 128'(st), 128'd0);

        // ECB, LEN=16, core inverts bits, src 00..0F
        for (int i = 0; i < 16; i++) mem[32'h100 + i] = 8'(i);
        core_mask = '1; core_lat = 3; rand_bus = 1'b0;
        run_job("ecb16", 'h100, 'h800, 16, 1'b0, 1'b0, 128'd0, 1'b0);
        chk("ecb16_first_byte", 128'(mem[32'h800]), 128'hFF);
        chk("ecb16_last_byte", 128'(mem[32'h80F]), 128'hF0);
        csr_peek(4'd9, st); chk("unmapped_read", 128'(st), 128'd0);

        // CBC decrypt, LEN=32, identity core, IV 00..0F
        core_mask = '0; core_lat = 1;
        iv = 128'h000102030405060708090A0B0C0D0E0F;
        run_job("cbcdec32", 'h100, 'h800, 32, 1'b1, 1'b1, iv, 1'b0);
        chk("cbcdec32_b0", 128'(mem[32'h805]), 128'(mem[32'h105] ^ 8'h05));
        chk("cbcdec32_b1", 128'(mem[32'h815]), 128'(mem[32'h115] ^ mem[32'h105]));
        csr_peek(4'd4, st); chk("iv0_readback", 128'(st), 128'h00010203);

        // ECB, LEN=48, random waitrequests
        rand_bus = 1'b1;
        core_mask = {$urandom, $urandom, $urandom, $urandom};
        core_lat = 2;
        run_job("ecb48_rand", 'h140, 'h900, 48, 1'b0, 1'b0, 128'd0, 1'b0);

        // random jobs in every mode
        for (int j = 0; j < 6; j++) begin
            core_mask = {$urandom, $urandom, $urandom, $urandom};
            core_lat  = int'($urandom_range(0, 4));
            iv        = {$urandom, $urandom, $urandom, $urandom};
            len = 16 * int'($urandom_range(1, 4));
            src = 'h100 + 4 * int'($urandom_range(0, 15));
            dst = 'h800 + 4 * int'($urandom_range(0, 15));
            run_job($sformatf("rand%0d", j), src, dst, len, 1'($urandom), 1'($urandom), iv,
                    1'b0);
        end

        // configuration errors
        rand_bus = 1'b0;
        run_bad("len20", 'h100, 'h800, 20);
        run_bad("len0", 'h100, 'h800, 0);
        run_bad("src_misaligned", 'h102, 'h800, 16);
        run_bad("dst_misaligned", 'h100, 'h801, 16);
        csr_write(4'd0, 32'h0);
        csr_peek(4'd0, st); chk("ctrl_clears_error", 128'(st), 128'd0);

        // restart and SRC write while busy are ignored
        rand_bus = 1'b1;
        core_mask = {$urandom, $urandom, $urandom, $urandom};
        iv = {$urandom, $urandom, $urandom, $urandom};
        run_job("poke", 'h100, 'h800, 64, 1'b1, 1'b0, iv, 1'b1);

        // reset while block 1 is being written, then a fresh job
        program_job('h100, 'h800, 32, iv);
        w0 = n_writes;
        csr_write(4'd0, 32'h3);
        cyc = 0;
        while (!((n_writes - w0) >= 4 && master2_write === 1'b1) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reached_block1", 128'(master2_write), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        csr_peek(4'd0, st); chk("midrst_status", 128'(st), 128'd0);
        csr_peek(4'd1, st); chk("midrst_src", 128'(st), 128'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        run_job("after_rst", 'h120, 'hA00, 48, 1'b1, 1'b0, iv, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
